// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity encodings, receiver FSM states
// and a constant-width helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_HIGH
  } rx_state_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div+1 clocks. A new divisor is
// picked up only on wrap so the tick spacing never glitches.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = (cnt == div_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= div;
    end else if (tick) begin
      cnt   <= '0;
      div_q <= div;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, run-time parity and stop
// bits, parity/framing/break flags, valid/ready output and idle/end-of-packet.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int IDLE_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_two_stop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_parity_err,
  output logic              m_frame_err,
  output logic              m_break,
  output logic              overrun,
  output logic              rx_idle,
  output logic              rx_eop
);

  localparam int CNT_W   = clog2(OVERSAMPLE);
  localparam int H       = OVERSAMPLE / 2;
  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GAP_W   = clog2(GAP_MAX + 1);
  localparam int IDX_W   = clog2(DATA_W);

  logic              tick;
  logic              rxd_meta, line;
  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              s0, s1, maj, mid, last;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic [1:0]        frm_parity;
  logic              frm_two_stop, par_en;
  logic              par_acc, par_err, any_one, stop1_bad, brk_q;
  logic              done, done_ferr, done_brk;
  logic [GAP_W-1:0]  gap;
  logic              frame_seen;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .div  (cfg_div),
    .tick (tick)
  );

  // NOTE: every flop is written with <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      line     <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      line     <= rxd_meta;
    end
  end

  assign maj    = (s0 & s1) | (s0 & line) | (s1 & line);
  assign mid    = tick && (cnt == CNT_W'(H + 1));
  assign last   = tick && (cnt == CNT_W'(OVERSAMPLE - 1));
  assign par_en = (frm_parity == PAR_EVEN) || (frm_parity == PAR_ODD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    done_ferr  = 1'b0;
    done_brk   = 1'b0;
    case (state)
      ST_IDLE:   if (tick && !line) state_next = ST_START;
      ST_START: begin
        if (mid && maj) state_next = ST_IDLE;
        else if (last)  state_next = ST_DATA;
      end
      ST_DATA:   if (last && bit_idx == IDX_W'(DATA_W - 1))
                   state_next = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (last) state_next = ST_STOP1;
      ST_STOP1: begin
        if (mid && !frm_two_stop) begin
          done       = 1'b1;
          done_ferr  = !maj;
          done_brk   = !any_one && !maj;
          state_next = maj ? ST_IDLE : ST_WAIT_HIGH;
        end else if (last && frm_two_stop) begin
          state_next = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (mid) begin
          done       = 1'b1;
          done_ferr  = stop1_bad | !maj;
          done_brk   = brk_q;
          state_next = done_ferr ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (tick && line) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bit timing, voting samples and the per-frame shifter/flag accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      s0           <= 1'b1;
      s1           <= 1'b1;
      bit_idx      <= '0;
      shift        <= '0;
      frm_parity   <= PAR_NONE;
      frm_two_stop <= 1'b0;
      par_acc      <= 1'b0;
      par_err      <= 1'b0;
      any_one      <= 1'b0;
      stop1_bad    <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= (state == ST_IDLE || state == ST_WAIT_HIGH) ? '0 : cnt + 1'b1;
        if (cnt == CNT_W'(H - 1)) s0 <= line;
        if (cnt == CNT_W'(H))     s1 <= line;
      end
      if (state == ST_IDLE && tick && !line) begin
        frm_parity   <= cfg_parity;
        frm_two_stop <= cfg_two_stop;
        bit_idx      <= '0;
        par_acc      <= 1'b0;
        par_err      <= 1'b0;
        any_one      <= 1'b0;
        stop1_bad    <= 1'b0;
        brk_q        <= 1'b0;
      end
      if (mid) begin
        case (state)
          ST_DATA: begin
            shift   <= {maj, shift[DATA_W-1:1]};
            par_acc <= par_acc ^ maj;
            any_one <= any_one | maj;
          end
          ST_PARITY: begin
            par_err <= (frm_parity == PAR_ODD) ? !(par_acc ^ maj) : (par_acc ^ maj);
            any_one <= any_one | maj;
          end
          ST_STOP1: begin
            stop1_bad <= !maj;
            brk_q     <= !any_one && !maj;
          end
          default: ;
        endcase
      end
      if (last && state == ST_DATA) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Output holding register; a frame finishing while one is still held is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_break      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!m_valid || m_ready) begin
          m_valid      <= 1'b1;
          m_data       <= shift;
          m_parity_err <= par_err;
          m_frame_err  <= done_ferr;
          m_break      <= done_brk;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign rx_idle = (gap == GAP_W'(GAP_MAX));

  // Gap counter starts saturated so a fresh link reports idle without an eop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap        <= GAP_W'(GAP_MAX);
      frame_seen <= 1'b0;
      rx_eop     <= 1'b0;
    end else begin
      rx_eop <= 1'b0;
      if (done) frame_seen <= 1'b1;
      if (state != ST_IDLE) begin
        gap <= '0;
      end else if (tick && !rx_idle) begin
        gap <= gap + 1'b1;
        if (gap == GAP_W'(GAP_MAX - 1)) begin
          rx_eop     <= frame_seen;
          frame_seen <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frame table, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [15:0] cfg_div;
  logic [1:0] cfg_parity;
  logic       cfg_two_stop;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       m_parity_err, m_frame_err, m_break, overrun, rx_idle, rx_eop;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       two;
    logic       pbit;
    logic       stop1;
    logic       stop2;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
  } frame_t;

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int eop_cnt = 0;
  int valid_cycles = 0;
  logic [10:0] got_q[$];
  frame_t vec[10];

  uart_rx_cfg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .cfg_div     (cfg_div),
    .cfg_parity  (cfg_parity),
    .cfg_two_stop(cfg_two_stop),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_parity_err(m_parity_err),
    .m_frame_err (m_frame_err),
    .m_break     (m_break),
    .overrun     (overrun),
    .rx_idle     (rx_idle),
    .rx_eop      (rx_eop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid && m_ready) got_q.push_back({m_data, m_parity_err, m_frame_err, m_break});
    if (m_valid) valid_cycles++;
    if (overrun) ov_cnt++;
    if (rx_eop)  eop_cnt++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input logic [1:0] pm, input logic two,
                                input logic pb, input logic s1, input logic s2,
                                input logic [7:0] ed, input logic ep, input logic ef,
                                input logic eb);
    frame_t f;
    f.data = d; f.pmode = pm; f.two = two; f.pbit = pb; f.stop1 = s1; f.stop2 = s2;
    f.e_data = ed; f.e_perr = ep; f.e_ferr = ef; f.e_brk = eb;
    return f;
  endfunction

  // Reference: expectations from the frame's wire contents alone.
  function automatic frame_t model(input frame_t f);
    frame_t r;
    int ones;
    bit pen;
    r    = f;
    ones = $countones(f.data);
    pen  = (f.pmode == 2'b01) || (f.pmode == 2'b10);
    r.e_data = f.data;
    r.e_perr = pen && ((((ones + int'(f.pbit)) % 2) == 1) != (f.pmode == 2'b10));
    r.e_ferr = !f.stop1 || (f.two && !f.stop2);
    r.e_brk  = (f.data == 8'h00) && !(pen && f.pbit) && !f.stop1;
    return r;
  endfunction

  task automatic drive_bit(input logic b, input bit glitch);
    rxd = b;
    if (glitch) begin
      repeat (30) @(negedge clk);
      rxd = ~b;
      repeat (4) @(negedge clk);
      rxd = b;
      repeat (30) @(negedge clk);
    end else begin
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic send_frame(input frame_t f, input int glitch_bit);
    cfg_parity   = f.pmode;
    cfg_two_stop = f.two;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(f.data[i], i == glitch_bit);
    if (f.pmode == PAR_EVEN || f.pmode == PAR_ODD) drive_bit(f.pbit, 1'b0);
    drive_bit(f.stop1, 1'b0);
    if (f.two) drive_bit(f.stop2, 1'b0);
    rxd = 1'b1;
  endtask

  task automatic idle(input int nbits);
    rxd = 1'b1;
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  task automatic expect_frame(input string name, input frame_t e);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no frame delivered, expected data 0x%0h", name, e.e_data);
    end else begin
      check(name, 32'(got_q.pop_front()), 32'({e.e_data, e.e_perr, e.e_ferr, e.e_brk}));
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    seen = m_valid;
  endtask

  initial begin
    frame_t f;
    bit seen;
    int v0, e0, o0;

    rst_n = 1'b0; rxd = 1'b1; cfg_div = 16'd3; cfg_parity = PAR_NONE;
    cfg_two_stop = 1'b0; m_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_flags", {m_parity_err, m_frame_err, m_break}, 0);
    check("rst_overrun_eop", {overrun, rx_eop}, 0);
    check("rst_rx_idle", rx_idle, 1);
    rst_n = 1'b1;
    idle(2);

    // 8N1 byte with idle/eop timing relative to the m_valid rise.
    v0 = valid_cycles; e0 = eop_cnt;
    fork
      send_frame(mk(8'hA5, PAR_NONE, 0, 0, 1, 1, 8'hA5, 0, 0, 0), -1);
      begin
        wait_valid(1500, seen);
        check("a5_valid_seen", seen, 1);
        repeat (110) @(negedge clk);
        check("a5_idle_low_in_gap", rx_idle, 0);
        repeat (30) @(negedge clk);
        check("a5_idle_high_after_gap", rx_idle, 1);
      end
    join
    expect_frame("a5_frame", mk(8'hA5, PAR_NONE, 0, 0, 1, 1, 8'hA5, 0, 0, 0));
    check("a5_valid_one_cycle", valid_cycles - v0, 1);
    check("a5_eop_once", eop_cnt - e0, 1);

    vec[0] = mk(8'h07, PAR_EVEN, 0, 0, 1, 1, 8'h07, 1, 0, 0);
    vec[1] = mk(8'h07, PAR_EVEN, 0, 1, 1, 1, 8'h07, 0, 0, 0);
    vec[2] = mk(8'h07, PAR_ODD,  0, 0, 1, 1, 8'h07, 0, 0, 0);
    vec[3] = mk(8'h55, PAR_NONE, 1, 0, 1, 0, 8'h55, 0, 1, 0);
    vec[4] = mk(8'h3C, PAR_NONE, 1, 0, 1, 1, 8'h3C, 0, 0, 0);
    vec[5] = mk(8'h81, 2'b11,    0, 1, 1, 1, 8'h81, 0, 0, 0);
    vec[6] = mk(8'hFF, PAR_ODD,  0, 0, 1, 1, 8'hFF, 1, 0, 0);
    vec[7] = mk(8'h00, PAR_EVEN, 0, 0, 0, 1, 8'h00, 0, 1, 1);
    vec[8] = mk(8'h80, PAR_NONE, 1, 0, 0, 1, 8'h80, 0, 1, 0);
    vec[9] = mk(8'h00, PAR_ODD,  1, 1, 0, 1, 8'h00, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      send_frame(vec[i], -1);
      idle(3);
      expect_frame($sformatf("table_%0d", i), vec[i]);
    end

    // Break: line low for 20 bit-times yields exactly one flagged frame.
    cfg_parity = PAR_NONE; cfg_two_stop = 1'b0;
    rxd = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    expect_frame("break_frame", mk(8'h00, PAR_NONE, 0, 0, 0, 0, 8'h00, 0, 1, 1));
    check("break_no_more_while_low", got_q.size(), 0);
    idle(3);
    check("break_no_more_after_high", got_q.size(), 0);

    // Overrun: second frame dropped while the first is held.
    m_ready = 1'b0; o0 = ov_cnt;
    send_frame(mk(8'h11, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), -1);
    send_frame(mk(8'h22, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), -1);
    idle(1);
    check("ovr_held_valid", m_valid, 1);
    check("ovr_held_data", m_data, 8'h11);
    check("ovr_pulse_once", ov_cnt - o0, 1);
    check("ovr_nothing_taken", got_q.size(), 0);
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_frame("ovr_accept", mk(8'h11, PAR_NONE, 0, 0, 1, 1, 8'h11, 0, 0, 0));
    check("ovr_valid_fell", m_valid, 0);
    idle(3);

    // Completion in the same cycle as a handshake: new frame loads, no overrun.
    m_ready = 1'b0; o0 = ov_cnt;
    fork
      begin
        send_frame(mk(8'h5C, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), -1);
        send_frame(mk(8'hC3, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), -1);
      end
      begin
        wait_valid(1500, seen);
        check("simul_first_valid", seen, 1);
        repeat (639) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(3);
    expect_frame("simul_first", mk(8'h5C, PAR_NONE, 0, 0, 1, 1, 8'h5C, 0, 0, 0));
    expect_frame("simul_second", mk(8'hC3, PAR_NONE, 0, 0, 1, 1, 8'hC3, 0, 0, 0));
    check("simul_no_overrun", ov_cnt - o0, 0);

    // Short low pulse is a false start.
    e0 = eop_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    idle(4);
    check("glitch_no_frame", got_q.size(), 0);
    check("glitch_back_idle", rx_idle, 1);
    check("glitch_no_eop", eop_cnt - e0, 0);

    // Single-tick high glitch inside data bit 3 of 0xF0.
    send_frame(mk(8'hF0, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), 3);
    idle(3);
    expect_frame("glitch_bit3", mk(8'hF0, PAR_NONE, 0, 0, 1, 1, 8'hF0, 0, 0, 0));

    // Reset mid-frame discards the partial frame.
    o0 = ov_cnt;
    cfg_parity = PAR_NONE; cfg_two_stop = 1'b0;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    check("midrst_valid_low", m_valid, 0);
    check("midrst_idle", rx_idle, 1);
    rst_n = 1'b1;
    idle(3);
    check("midrst_no_frame", got_q.size(), 0);
    check("midrst_no_overrun", ov_cnt - o0, 0);
    send_frame(mk(8'h5A, PAR_NONE, 0, 0, 1, 1, 0, 0, 0, 0), -1);
    idle(3);
    expect_frame("midrst_next", mk(8'h5A, PAR_NONE, 0, 0, 1, 1, 8'h5A, 0, 0, 0));

    // Random frames against the reference model.
    for (int i = 0; i < 16; i++) begin
      f.data  = 8'($urandom);
      f.pmode = 2'($urandom_range(0, 3));
      f.two   = 1'($urandom_range(0, 1));
      f.pbit  = ((f.pmode == PAR_ODD) ? ~(^f.data) : (^f.data)) ^ ($urandom_range(0, 3) == 0);
      f.stop1 = ($urandom_range(0, 5) != 0);
      f.stop2 = ($urandom_range(0, 5) != 0);
      f = model(f);
      send_frame(f, -1);
      idle(3);
      expect_frame($sformatf("rand_%0d", i), f);
    end

    check("final_queue_empty", got_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
